// File: rtl/ray_pkg.sv
// Shared types and constants for the ray sweep sequencer and the column renderer.
package ray_pkg;

    localparam int unsigned COORD_W    = 12;
    localparam int unsigned ANGLE_FULL = 1920;
    localparam int unsigned FOV_HALF   = 160;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StPresent,
        StDone
    } ray_state_e;

    typedef struct packed {
        logic               found;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } col_result_t;

endpackage

// File: rtl/angle_wrap_step.sv
// Combinational add/subtract of an angle delta modulo ANGLE_FULL.
module angle_wrap_step
    import ray_pkg::*;
(
    input  logic [COORD_W-1:0] i_angle,
    input  logic [COORD_W-1:0] i_delta,
    input  logic               i_sub,
    output logic [COORD_W-1:0] o_angle
);

    localparam logic [COORD_W:0] FULL13 = (COORD_W + 1)'(ANGLE_FULL);

    logic [COORD_W:0] w_base;
    logic [COORD_W:0] w_delta;
    logic [COORD_W:0] w_sum;

    always_comb begin
        w_delta = {1'b0, i_delta};
        w_base  = {1'b0, i_angle};
        // Out-of-range inputs are folded once before stepping.
        if (w_base >= FULL13) begin
            w_base = w_base - FULL13;
        end
        if (i_sub) begin
            if (w_base < w_delta) begin
                w_sum = w_base + FULL13 - w_delta;
            end else begin
                w_sum = w_base - w_delta;
            end
        end else begin
            w_sum = w_base + w_delta;
            if (w_sum >= FULL13) begin
                w_sum = w_sum - FULL13;
            end
        end
        o_angle = w_sum[COORD_W-1:0];
    end

endmodule

// File: rtl/ray_sweep_sequencer.sv
// Sweeps the ray angle across the screen, one finder round per column, and hands results on.
// Optional per-column watchdog: define RAY_SWEEP_TIMEOUT_EN.
module ray_sweep_sequencer
    import ray_pkg::*;
#(
    parameter int unsigned NUM_COLS   = 320,
    parameter int unsigned ANGLE_STEP = 1,
    parameter int unsigned MAX_CYCLES = 1023
) (
    input  logic               i_clock,
    input  logic               i_resetn,
    input  logic               i_start_frame,
    input  logic [COORD_W-1:0] i_player_x,
    input  logic [COORD_W-1:0] i_player_y,
    input  logic [COORD_W-1:0] i_player_angle,
    output logic [COORD_W-1:0] o_ray_x,
    output logic [COORD_W-1:0] o_ray_y,
    output logic [COORD_W-1:0] o_alpha,
    output logic               o_begin_calc,
    input  logic               i_h_end_calc,
    input  logic               i_v_end_calc,
    input  logic               i_h_wall_found,
    input  logic               i_v_wall_found,
    input  logic [COORD_W-1:0] i_h_wall_x,
    input  logic [COORD_W-1:0] i_h_wall_y,
    input  logic [COORD_W-1:0] i_v_wall_x,
    input  logic [COORD_W-1:0] i_v_wall_y,
    output logic               o_col_valid,
    input  logic               i_col_ack,
    output logic [8:0]         o_col_index,
    output logic               o_col_h_found,
    output logic               o_col_v_found,
    output logic [COORD_W-1:0] o_col_h_x,
    output logic [COORD_W-1:0] o_col_h_y,
    output logic [COORD_W-1:0] o_col_v_x,
    output logic [COORD_W-1:0] o_col_v_y,
    output logic               o_frame_busy,
    output logic               o_frame_done
`ifdef RAY_SWEEP_TIMEOUT_EN
    ,
    output logic               o_timeout_seen
`endif
);

    ray_state_e         r_state;
    ray_state_e         w_state_next;
    logic [COORD_W-1:0] r_ray_x;
    logic [COORD_W-1:0] r_ray_y;
    logic [COORD_W-1:0] r_alpha;
    logic [8:0]         r_col_index;
    logic               r_h_done;
    logic               r_v_done;
    col_result_t        r_h_res;
    col_result_t        r_v_res;

    logic [COORD_W-1:0] w_start_alpha;
    logic [COORD_W-1:0] w_step_alpha;
    logic               w_h_done_next;
    logic               w_v_done_next;
    logic               w_last_col;
    logic               w_timeout;

    angle_wrap_step u_start_angle (
        .i_angle (i_player_angle),
        .i_delta (COORD_W'(FOV_HALF)),
        .i_sub   (1'b0),
        .o_angle (w_start_alpha)
    );

    angle_wrap_step u_step_angle (
        .i_angle (r_alpha),
        .i_delta (COORD_W'(ANGLE_STEP)),
        .i_sub   (1'b1),
        .o_angle (w_step_alpha)
    );

    assign w_h_done_next = r_h_done | i_h_end_calc;
    assign w_v_done_next = r_v_done | i_v_end_calc;
    assign w_last_col    = (r_col_index == 9'(NUM_COLS - 1));

`ifdef RAY_SWEEP_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout_seen;

    assign w_timeout      = (r_state == StWait) && (r_wait_cnt == CNT_W'(MAX_CYCLES - 1));
    assign o_timeout_seen = r_timeout_seen;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_wait_cnt     <= '0;
            r_timeout_seen <= 1'b0;
        end else begin
            if (r_state == StIssue) begin
                r_wait_cnt <= '0;
            end else if (r_state == StWait) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            if (r_state == StIdle && i_start_frame) begin
                r_timeout_seen <= 1'b0;
            end else if (w_timeout && !(w_h_done_next && w_v_done_next)) begin
                r_timeout_seen <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0 && (MAX_CYCLES != 0);
`endif

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (i_start_frame) w_state_next = StIssue;
            StIssue:   w_state_next = StWait;
            StWait:    if ((w_h_done_next && w_v_done_next) || w_timeout) w_state_next = StPresent;
            StPresent: if (i_col_ack) w_state_next = w_last_col ? StDone : StIssue;
            StDone:    w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_begin_calc = (r_state == StIssue);
        o_col_valid  = (r_state == StPresent);
        o_frame_done = (r_state == StDone);
        o_frame_busy = (r_state == StIssue) || (r_state == StWait) || (r_state == StPresent);
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_ray_x     <= '0;
            r_ray_y     <= '0;
            r_alpha     <= '0;
            r_col_index <= '0;
            r_h_done    <= 1'b0;
            r_v_done    <= 1'b0;
            r_h_res     <= '0;
            r_v_res     <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start_frame) begin
                        r_ray_x     <= i_player_x;
                        r_ray_y     <= i_player_y;
                        r_alpha     <= w_start_alpha;
                        r_col_index <= '0;
                    end
                end
                StIssue: begin
                    r_h_done <= 1'b0;
                    r_v_done <= 1'b0;
                end
                StWait: begin
                    // A side that is already done ignores repeat end_calc pulses.
                    if (!r_h_done && i_h_end_calc) begin
                        r_h_done <= 1'b1;
                        r_h_res  <= '{found: i_h_wall_found, x: i_h_wall_x, y: i_h_wall_y};
                    end else if (!r_h_done && w_timeout) begin
                        r_h_done <= 1'b1;
                        r_h_res  <= '0;
                    end
                    if (!r_v_done && i_v_end_calc) begin
                        r_v_done <= 1'b1;
                        r_v_res  <= '{found: i_v_wall_found, x: i_v_wall_x, y: i_v_wall_y};
                    end else if (!r_v_done && w_timeout) begin
                        r_v_done <= 1'b1;
                        r_v_res  <= '0;
                    end
                end
                StPresent: begin
                    if (i_col_ack && !w_last_col) begin
                        r_col_index <= r_col_index + 9'd1;
                        r_alpha     <= w_step_alpha;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ray_x       = r_ray_x;
    assign o_ray_y       = r_ray_y;
    assign o_alpha       = r_alpha;
    assign o_col_index   = r_col_index;
    assign o_col_h_found = r_h_res.found;
    assign o_col_h_x     = r_h_res.x;
    assign o_col_h_y     = r_h_res.y;
    assign o_col_v_found = r_v_res.found;
    assign o_col_v_x     = r_v_res.x;
    assign o_col_v_y     = r_v_res.y;

endmodule

// File: tb/tb_ray_sweep_sequencer.sv
// Directed bench for ray_sweep_sequencer; a small finder responder answers each begin_calc.
module tb_ray_sweep_sequencer;

    logic        i_clock = 1'b0;
    logic        i_resetn = 1'b0;
    logic        i_start_frame = 1'b0;
    logic [11:0] i_player_x = '0;
    logic [11:0] i_player_y = '0;
    logic [11:0] i_player_angle = '0;
    logic [11:0] o_ray_x, o_ray_y, o_alpha;
    logic        o_begin_calc;
    logic        i_h_end_calc = 1'b0;
    logic        i_v_end_calc = 1'b0;
    logic        i_h_wall_found = 1'b0;
    logic        i_v_wall_found = 1'b0;
    logic [11:0] i_h_wall_x = '0, i_h_wall_y = '0, i_v_wall_x = '0, i_v_wall_y = '0;
    logic        o_col_valid;
    logic        i_col_ack = 1'b0;
    logic [8:0]  o_col_index;
    logic        o_col_h_found, o_col_v_found;
    logic [11:0] o_col_h_x, o_col_h_y, o_col_v_x, o_col_v_y;
    logic        o_frame_busy, o_frame_done;
`ifdef RAY_SWEEP_TIMEOUT_EN
    logic        o_timeout_seen;
`endif

    always #10 i_clock = ~i_clock;

    ray_sweep_sequencer #(
        .NUM_COLS   (320),
        .ANGLE_STEP (1),
        .MAX_CYCLES (15)
    ) dut (
        .i_clock        (i_clock),
        .i_resetn       (i_resetn),
        .i_start_frame  (i_start_frame),
        .i_player_x     (i_player_x),
        .i_player_y     (i_player_y),
        .i_player_angle (i_player_angle),
        .o_ray_x        (o_ray_x),
        .o_ray_y        (o_ray_y),
        .o_alpha        (o_alpha),
        .o_begin_calc   (o_begin_calc),
        .i_h_end_calc   (i_h_end_calc),
        .i_v_end_calc   (i_v_end_calc),
        .i_h_wall_found (i_h_wall_found),
        .i_v_wall_found (i_v_wall_found),
        .i_h_wall_x     (i_h_wall_x),
        .i_h_wall_y     (i_h_wall_y),
        .i_v_wall_x     (i_v_wall_x),
        .i_v_wall_y     (i_v_wall_y),
        .o_col_valid    (o_col_valid),
        .i_col_ack      (i_col_ack),
        .o_col_index    (o_col_index),
        .o_col_h_found  (o_col_h_found),
        .o_col_v_found  (o_col_v_found),
        .o_col_h_x      (o_col_h_x),
        .o_col_h_y      (o_col_h_y),
        .o_col_v_x      (o_col_v_x),
        .o_col_v_y      (o_col_v_y),
        .o_frame_busy   (o_frame_busy),
        .o_frame_done   (o_frame_done)
`ifdef RAY_SWEEP_TIMEOUT_EN
        ,
        .o_timeout_seen (o_timeout_seen)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Finder model: rcnt is the WAIT cycle number, 0 in the ISSUE cycle.
    int h_dly = 5;
    int v_dly = 5;
    int rcnt  = 1000;
    always @(negedge i_clock) begin
        if (o_begin_calc) rcnt = 0;
        else rcnt = rcnt + 1;
        i_h_end_calc = (rcnt == h_dly);
        i_v_end_calc = (rcnt == v_dly);
    end

    int n_begin = 0;
    int n_acc = 0;
    int n_done = 0;
    logic [11:0] alpha_first = '0;
    logic [11:0] alpha_last = '0;
    always @(negedge i_clock) begin
        if (o_begin_calc) n_begin = n_begin + 1;
        if (o_frame_done) n_done = n_done + 1;
        if (o_col_valid && i_col_ack) begin
            n_acc = n_acc + 1;
            if (o_col_index == 9'd0) alpha_first = o_alpha;
            if (o_col_index == 9'd319) alpha_last = o_alpha;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_sample;
        @(negedge i_clock);
        #2;
    endtask

    task automatic drive_edge;
        @(posedge i_clock);
        #1;
    endtask

    task automatic pulse_start;
        drive_edge();
        i_start_frame = 1'b1;
        drive_edge();
        i_start_frame = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int n = 0;
        while (!o_col_valid && n < budget) begin
            next_sample();
            n++;
        end
        check(tag, o_col_valid, 1);
    endtask

    initial begin
        int nb0, nd0, nacc0, bad;
        logic [127:0] snap;

        // Reset state
        repeat (3) next_sample();
        check("rst_ray", {o_ray_x, o_ray_y}, 0);
        check("rst_alpha", o_alpha, 0);
        check("rst_ctrl", {o_begin_calc, o_col_valid, o_frame_busy, o_frame_done}, 0);
        check("rst_col", {o_col_index, o_col_h_found, o_col_v_found}, 0);
        check("rst_coords", {o_col_h_x, o_col_h_y, o_col_v_x, o_col_v_y}, 0);
        drive_edge();
        i_resetn = 1'b1;

        // Full frame, angle 100, finders at 5 cycles, ack held high
        i_player_x = 12'd100;
        i_player_y = 12'd200;
        i_player_angle = 12'd100;
        i_h_wall_found = 1'b1; i_h_wall_x = 12'd11; i_h_wall_y = 12'd22;
        i_v_wall_found = 1'b0; i_v_wall_x = 12'd33; i_v_wall_y = 12'd44;
        h_dly = 5; v_dly = 5;
        i_col_ack = 1'b1;
        pulse_start();
        next_sample();
        check("a_issue", {o_begin_calc, o_frame_busy}, 2'b11);
        check("a_alpha0", o_alpha, 260);
        check("a_ray", {o_ray_x, o_ray_y}, {12'd100, 12'd200});
        repeat (100) next_sample();
        i_player_angle = 12'd500;
        i_player_x = 12'd999;
        pulse_start();
        begin
            int n = 0;
            while (n_done == 0 && n < 5000) begin
                next_sample();
                n++;
            end
        end
        check("a_done_cnt", n_done, 1);
        check("a_begin_cnt", n_begin, 320);
        check("a_acc_cnt", n_acc, 320);
        check("a_alpha_first", alpha_first, 260);
        check("a_alpha_last", alpha_last, 1861);
        check("a_ray_kept", o_ray_x, 100);
        next_sample();
        check("a_idle", {o_frame_busy, o_frame_done, o_col_valid}, 0);

        // Angle wrap at start, staggered finder ends, ack held low
        i_col_ack = 1'b0;
        i_player_angle = 12'd1800;
        i_h_wall_found = 1'b1; i_h_wall_x = 12'd64; i_h_wall_y = 12'd128;
        i_v_wall_found = 1'b0; i_v_wall_x = 12'd5; i_v_wall_y = 12'd6;
        h_dly = 3; v_dly = 9;
        pulse_start();
        wait_valid(100, "b_valid");
        check("b_latency", rcnt, 10);
        check("b_alpha", o_alpha, 40);
        check("b_h", {o_col_h_found, o_col_h_x, o_col_h_y}, {1'b1, 12'd64, 12'd128});
        check("b_v_found", o_col_v_found, 0);
        check("b_index", o_col_index, 0);
        snap = {o_alpha, o_ray_x, o_ray_y, o_col_index, o_col_h_found, o_col_v_found,
                o_col_h_x, o_col_h_y, o_col_v_x, o_col_v_y};
        nb0 = n_begin;
        bad = 0;
        repeat (20) begin
            next_sample();
            if (snap !== {o_alpha, o_ray_x, o_ray_y, o_col_index, o_col_h_found, o_col_v_found,
                          o_col_h_x, o_col_h_y, o_col_v_x, o_col_v_y}) bad++;
        end
        check("hold_stable", bad, 0);
        check("hold_no_begin", n_begin - nb0, 0);
        check("hold_valid", o_col_valid, 1);

        // Same-cycle finder ends on column 1
        h_dly = 4; v_dly = 4;
        i_h_wall_found = 1'b1; i_h_wall_x = 12'd10; i_h_wall_y = 12'd20;
        i_v_wall_found = 1'b1; i_v_wall_x = 12'd30; i_v_wall_y = 12'd40;
        drive_edge();
        i_col_ack = 1'b1;
        drive_edge();
        i_col_ack = 1'b0;
        next_sample();
        check("c_issue", {o_begin_calc, o_col_valid}, 2'b10);
        check("c_index", o_col_index, 1);
        check("c_alpha", o_alpha, 39);
        wait_valid(100, "c_valid");
        check("c_latency", rcnt, 5);
        check("c_h", {o_col_h_found, o_col_h_x, o_col_h_y}, {1'b1, 12'd10, 12'd20});
        check("c_v", {o_col_v_found, o_col_v_x, o_col_v_y}, {1'b1, 12'd30, 12'd40});

        // Reset in WAIT of column 37
        h_dly = 5; v_dly = 5;
        drive_edge();
        i_col_ack = 1'b1;
        begin
            int n = 0;
            while (!(o_begin_calc && o_col_index == 9'd37) && n < 1000) begin
                next_sample();
                n++;
            end
        end
        check("d_reach37", {o_begin_calc, o_col_index}, {1'b1, 9'd37});
        next_sample();
        next_sample();
        nd0 = n_done;
        nacc0 = n_acc;
        i_resetn = 1'b0;
        #1;
        check("d_ctrl", {o_begin_calc, o_col_valid, o_frame_busy, o_frame_done}, 0);
        check("d_pos", {o_ray_x, o_ray_y, o_alpha, o_col_index}, 0);
        check("d_col", {o_col_h_found, o_col_v_found, o_col_h_x, o_col_h_y, o_col_v_x, o_col_v_y}, 0);
        repeat (3) next_sample();
        check("d_no_done", n_done - nd0, 0);
        check("d_no_acc", n_acc - nacc0, 0);
        drive_edge();
        i_resetn = 1'b1;
        i_col_ack = 1'b0;
        i_player_angle = 12'd2000;
        pulse_start();
        wait_valid(100, "d_valid");
        check("d_index0", o_col_index, 0);
        check("d_alpha", o_alpha, 240);

`ifdef RAY_SWEEP_TIMEOUT_EN
        // Vertical finder never answers
        drive_edge();
        i_resetn = 1'b0;
        next_sample();
        check("t_rst_seen", o_timeout_seen, 0);
        drive_edge();
        i_resetn = 1'b1;
        h_dly = 2; v_dly = 100000;
        i_h_wall_found = 1'b1; i_h_wall_x = 12'd7; i_h_wall_y = 12'd8;
        i_v_wall_found = 1'b1; i_v_wall_x = 12'd9; i_v_wall_y = 12'd9;
        pulse_start();
        wait_valid(100, "t_valid");
        check("t_latency", rcnt, 16);
        check("t_v", {o_col_v_found, o_col_v_x, o_col_v_y}, 0);
        check("t_h", {o_col_h_found, o_col_h_x, o_col_h_y}, {1'b1, 12'd7, 12'd8});
        check("t_seen", o_timeout_seen, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ray_sweep_sequencer.md
Name: ray_sweep_sequencer

Overview:
- Upstream stage of the horizontal and vertical wall-intersection finders.
- On each frame request it sweeps the ray angle across the field of view, one screen column at a time.
- For each column it pulses begin_calc to both finders, then waits until each has raised end_calc.
- It captures both finders' wall results and hands them to the column renderer with a valid/ack handshake.

Parameters:
- NUM_COLS, 320, columns per frame (one ray per column).
- ANGLE_FULL, 1920, angle units per full circle; alpha is always in 0..ANGLE_FULL-1.
- FOV_HALF, 160, half field of view in angle units.
- ANGLE_STEP, 1, angle decrement per column.
- MAX_CYCLES, 1023, watchdog limit per column (used only with the optional feature).

Ports:
- clock  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous active-low reset.
- start_frame  in  1  single-cycle request to begin a sweep.
- playerX, playerY  in  12 each  player position, sampled at frame start.
- player_angle  in  12  player heading, sampled at frame start.
- rayX, rayY  out  12 each  latched player position driven to both finders.
- alpha  out  12  current ray angle driven to both finders.
- begin_calc  out  1  one-cycle pulse to both finders.
- h_end_calc, v_end_calc  in  1 each  end_calc from the horizontal and vertical finders.
- h_wall_found, v_wall_found  in  1 each  wall_found from each finder, valid with its end_calc.
- h_wallX, h_wallY, v_wallX, v_wallY  in  12 each  wall coordinates, valid with the matching end_calc.
- col_valid  out  1  column result available.
- col_ack  in  1  renderer accepts the column result.
- col_index  out  9  column number, 0..NUM_COLS-1.
- col_h_found, col_v_found  out  1 each  captured wall_found flags.
- col_hX, col_hY, col_vX, col_vY  out  12 each  captured wall coordinates.
- frame_busy  out  1  high from frame acceptance until frame_done.
- frame_done  out  1  one-cycle pulse after the last column is acknowledged.

Behaviour:
- Reset: every output is 0, FSM is in IDLE, internal done flags and counters are cleared. Reset asserted mid-frame aborts the frame immediately; no frame_done is issued.
- IDLE:
  - On start_frame, latch playerX/playerY into rayX/rayY.
  - Set alpha = player_angle + FOV_HALF, minus ANGLE_FULL if the sum is >= ANGLE_FULL. Compute at 13 bits; player_angle >= ANGLE_FULL is reduced once by ANGLE_FULL before adding.
  - Set col_index = 0, frame_busy = 1, go to ISSUE.
- ISSUE: begin_calc = 1 for exactly this cycle; clear both done flags; go to WAIT. rayX/rayY/alpha are stable from ISSUE until the column leaves PRESENT.
- WAIT:
  - On h_end_calc, set h_done and capture h_wall_found/h_wallX/h_wallY. v_end_calc does the same for the vertical side.
  - The two ends may arrive in either order or in the same cycle; each side is captured in the cycle its end_calc is high.
  - When both sides are done (including same-cycle arrival), go to PRESENT on the next edge.
  - A repeat end_calc from an already-done side is ignored.
- PRESENT:
  - col_valid = 1; all col_* outputs are held constant until col_ack is sampled high.
  - When col_valid && col_ack and col_index == NUM_COLS-1: go to DONE.
  - Otherwise: col_index += 1; alpha = alpha - ANGLE_STEP, plus ANGLE_FULL on underflow (wrap 0 -> ANGLE_FULL-1); go to ISSUE.
  - col_valid falls in the cycle after the accepting edge.
- DONE: frame_done = 1 for one cycle, frame_busy = 0, return to IDLE.
- start_frame while frame_busy is ignored (not queued).
- Column latency with a same-cycle ack: ISSUE 1 cycle + finder time + 1 cycle to PRESENT + 1 cycle.

Optional Feature:
- Macro: RAY_SWEEP_TIMEOUT_EN.
- Defined:
  - A per-column counter runs in WAIT.
  - If it reaches MAX_CYCLES, any side not yet done is forced done with found = 0 and coordinates = 0.
  - The FSM then enters PRESENT and sticky output timeout_seen (1 bit, cleared at frame start and at reset) goes high.
- Not defined: no counter, no timeout_seen port; WAIT waits indefinitely.

Decomposition:
- Shared package ray_pkg holds:
  - the ANGLE_FULL and FOV_HALF constants;
  - the 12-bit coordinate/angle width constant;
  - the FSM state encoding (IDLE, ISSUE, WAIT, PRESENT, DONE);
  - a column-result struct {found, X, Y} shared with the renderer.
- One natural sub-module, angle_wrap_step: combinational add/subtract modulo ANGLE_FULL, used for the start angle and the per-column step.

Test Plan:
- Reset mid-WAIT at column 37 -> all outputs 0 next cycle; a new start_frame sweeps from col_index 0.
- player_angle=100, finders ending after 5 cycles, col_ack held 1 -> column 0 alpha=260, column 319 alpha=1861 (wrapped); 320 col_valid pulses; one frame_done; exactly 320 begin_calc pulses.
- player_angle=1800 -> start alpha=40 (1960-1920).
- h_end_calc at WAIT cycle 3 with wall (64,128), v_end_calc at cycle 9 with no wall -> PRESENT one cycle after cycle 9; col_h_found=1, col_hX=64, col_hY=128, col_v_found=0.
- Both end_calc in the same cycle -> PRESENT next cycle with both results captured.
- col_ack held low 20 cycles in PRESENT -> col_* outputs stable, no begin_calc. Separately, start_frame during frame -> ignored, sweep unaffected.
- With RAY_SWEEP_TIMEOUT_EN, MAX_CYCLES=15, v finder never ends -> PRESENT after 15 WAIT cycles, col_v_found=0, timeout_seen=1.
